// File: rtl/vm_pkg.sv
// vm_pkg: controller state encoding and coin code constants for vending_machine_param
package vm_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} vm_state_t;
  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_A_C  = 2'b01;
  localparam logic [1:0] COIN_B_C  = 2'b10;
  localparam logic [1:0] COIN_C_C  = 2'b11;
endpackage

// File: rtl/vm_stock.sv
// vm_stock: per-item stock counters, reloaded on reset, decremented on accepted purchases
module vm_stock
  import vm_pkg::*;
#(
  parameter int NUM_ITEMS  = 4,
  parameter int STOCK_INIT = 8,
  parameter int SEL_W      = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_dec,
  input  logic [SEL_W-1:0]     i_idx,
  output logic                 o_avail,
  output logic [NUM_ITEMS-1:0] o_sold_out
);
  localparam int SW = (STOCK_INIT > 0) ? $clog2(STOCK_INIT + 1) : 1;
  logic w_in_range;
  assign w_in_range = 32'(i_idx) < NUM_ITEMS;
  assign o_avail = w_in_range && !o_sold_out[i_idx];
  for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_item
    logic [SW-1:0] r_cnt;
    // count down on a purchase of this item; the zero guard keeps it from wrapping
    always_ff @(posedge clk) begin
      if (reset) r_cnt <= SW'(STOCK_INIT);
      else if (i_dec && i_idx == SEL_W'(i) && r_cnt != '0) r_cnt <= r_cnt - SW'(1);
    end
    assign o_sold_out[i] = r_cnt == '0;
  end
endmodule

// File: rtl/vending_machine_param.sv
// vending_machine_param: multi-item coin vending controller with credit, stock and unit change payout; VM_REFUND_EN adds a cancel/refund input
module vending_machine_param
  import vm_pkg::*;
#(
  parameter int NUM_ITEMS  = 4,
  parameter int PRICE      = 3,
  parameter int COIN_A     = 1,
  parameter int COIN_B     = 2,
  parameter int COIN_C     = 5,
  parameter int STOCK_INIT = 8,
  parameter int CREDIT_W   = 5,
  localparam int SEL_W     = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           coin,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 buy,
`ifdef VM_REFUND_EN
  input  logic                 cancel,
`endif
  output logic                 product,
  output logic [SEL_W-1:0]     product_id,
  output logic                 change,
  output logic                 reject,
  output logic                 deny,
  output logic [CREDIT_W-1:0]  credit,
  output logic                 busy,
  output logic [NUM_ITEMS-1:0] sold_out
);
  localparam int CW1 = CREDIT_W + 1;
  localparam logic [CREDIT_W:0]   CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};
  localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);
  vm_state_t           r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic [SEL_W-1:0]    r_pid;
  logic                r_product, r_change, r_reject, r_deny, r_busy;
  logic [CREDIT_W:0]   w_coin_val, w_sum;
  logic                w_idle_col, w_avail, w_buy_ok, w_deny, w_cancel_ok, w_coin, w_coin_ok;
  assign w_coin_val = coin == COIN_A_C ? CW1'(COIN_A)
                    : coin == COIN_B_C ? CW1'(COIN_B)
                    : coin == COIN_C_C ? CW1'(COIN_C) : '0;
  assign w_sum      = {1'b0, r_credit} + w_coin_val;
  assign w_coin     = coin != COIN_NONE;
  assign w_idle_col = r_state == IDLE || r_state == COLLECT;
  assign w_buy_ok   = buy && w_idle_col && r_credit >= PRICE_C && w_avail;
  assign w_deny     = buy && w_idle_col && !w_buy_ok;
`ifdef VM_REFUND_EN
  assign w_cancel_ok = cancel && r_state == COLLECT && !w_buy_ok;
`else
  assign w_cancel_ok = 1'b0;
`endif
  // a coin only lands when nothing higher-priority claims the cycle and it fits the credit register
  assign w_coin_ok  = w_coin && w_idle_col && !w_buy_ok && !w_cancel_ok && w_sum <= CREDIT_MAX;
  vm_stock #(
    .NUM_ITEMS (NUM_ITEMS),
    .STOCK_INIT(STOCK_INIT),
    .SEL_W     (SEL_W)
  ) u_stock (
    .clk       (clk),
    .reset     (reset),
    .i_dec     (w_buy_ok),
    .i_idx     (sel),
    .o_avail   (w_avail),
    .o_sold_out(sold_out)
  );
  // controller FSM: credit accumulation, vend, and one-unit-per-cycle change payout with registered pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_credit  <= '0;
      r_pid     <= '0;
      r_product <= 1'b0;
      r_change  <= 1'b0;
      r_reject  <= 1'b0;
      r_deny    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_product <= 1'b0;
      r_pid     <= '0;
      r_change  <= 1'b0;
      r_reject  <= w_coin && !w_coin_ok;
      r_deny    <= w_deny;
      case (r_state)
        IDLE, COLLECT: begin
          r_busy <= w_buy_ok || w_cancel_ok;
          if (w_buy_ok) begin
            r_state   <= VEND;
            r_credit  <= r_credit - PRICE_C;
            r_product <= 1'b1;
            r_pid     <= sel;
          end else if (w_cancel_ok) begin
            r_state  <= CHANGE;
            r_credit <= r_credit - CREDIT_W'(1);
            r_change <= 1'b1;
          end else if (w_coin_ok) begin
            r_state  <= COLLECT;
            r_credit <= w_sum[CREDIT_W-1:0];
          end
        end
        default: begin
          r_busy  <= r_credit != '0;
          r_state <= r_credit != '0 ? CHANGE : IDLE;
          if (r_credit != '0) begin
            r_credit <= r_credit - CREDIT_W'(1);
            r_change <= 1'b1;
          end
        end
      endcase
    end
  end
  assign product    = r_product;
  assign product_id = r_pid;
  assign change     = r_change;
  assign reject     = r_reject;
  assign deny       = r_deny;
  assign credit     = r_credit;
  assign busy       = r_busy;
endmodule

// File: tb/tb_vending_machine_param.sv
// tb_vending_machine_param: directed scenarios plus randomized transactions against a credit/stock reference model
module tb_vending_machine_param;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] coin = 2'b00;
  logic [1:0] sel = 2'b00;
  logic       buy = 1'b0;
`ifdef VM_REFUND_EN
  logic       cancel = 1'b0;
`endif
  logic       product, change, reject, deny, busy;
  logic [1:0] product_id;
  logic [4:0] credit;
  logic [3:0] sold_out;
  int passed = 0;
  int total = 0;
  int m_credit;
  int m_stock[4];
  int coin_val[4] = '{0, 1, 2, 5};

  vending_machine_param dut (
    .clk(clk), .reset(reset), .coin(coin), .sel(sel), .buy(buy),
`ifdef VM_REFUND_EN
    .cancel(cancel),
`endif
    .product(product), .product_id(product_id), .change(change), .reject(reject),
    .deny(deny), .credit(credit), .busy(busy), .sold_out(sold_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; coin = 2'b00; buy = 1'b0; sel = 2'b00;
`ifdef VM_REFUND_EN
    cancel = 1'b0;
`endif
    tick(); tick();
    reset = 1'b0;
    m_credit = 0;
    foreach (m_stock[i]) m_stock[i] = 8;
  endtask

  task automatic put_coin(input logic [1:0] c);
    coin = c; tick(); coin = 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b1; coin = 2'b11; buy = 1'b1; sel = 2'd1;
    tick(); tick();
    total++; if ({product, product_id, change, reject, deny, busy} !== 7'd0) $display("FAIL reset_pulses got=%b exp=0", {product, product_id, change, reject, deny, busy}); else passed++;
    total++; if (credit !== 5'd0) $display("FAIL reset_credit got=%0d exp=0", credit); else passed++;
    total++; if (sold_out !== 4'b0000) $display("FAIL reset_sold_out got=%b exp=0000", sold_out); else passed++;
    coin = 2'b00; buy = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_exact();
    do_reset();
    put_coin(2'b01);
    total++; if (credit !== 5'd1) $display("FAIL exact_coin_a got=%0d exp=1", credit); else passed++;
    put_coin(2'b10);
    total++; if (credit !== 5'd3) $display("FAIL exact_coin_b got=%0d exp=3", credit); else passed++;
    sel = 2'd2; buy = 1'b1; tick(); buy = 1'b0;
    total++; if ({product, product_id, busy, change} !== 5'b1_10_1_0) $display("FAIL exact_vend got=%b exp=11010", {product, product_id, busy, change}); else passed++;
    total++; if (credit !== 5'd0) $display("FAIL exact_vend_credit got=%0d exp=0", credit); else passed++;
    tick();
    total++; if ({product, product_id, busy, change} !== 5'd0) $display("FAIL exact_idle got=%b exp=00000", {product, product_id, busy, change}); else passed++;
    tick();
    total++; if (change !== 1'b0) $display("FAIL exact_no_change got=%b exp=0", change); else passed++;
  endtask

  task automatic test_change();
    do_reset();
    put_coin(2'b11);
    total++; if (credit !== 5'd5) $display("FAIL chg_credit5 got=%0d exp=5", credit); else passed++;
    sel = 2'd0; buy = 1'b1; tick(); buy = 1'b0;
    total++; if (product !== 1'b1 || credit !== 5'd2) $display("FAIL chg_vend product=%b credit=%0d exp product=1 credit=2", product, credit); else passed++;
    tick();
    total++; if (change !== 1'b1 || credit !== 5'd1 || product !== 1'b0) $display("FAIL chg_pulse1 change=%b credit=%0d product=%b exp 1/1/0", change, credit, product); else passed++;
    coin = 2'b01; tick(); coin = 2'b00;
    total++; if ({change, reject} !== 2'b11 || credit !== 5'd0) $display("FAIL chg_pulse2 change,reject=%b credit=%0d exp 11/0", {change, reject}, credit); else passed++;
    tick();
    total++; if ({change, busy, reject} !== 3'b000 || credit !== 5'd0) $display("FAIL chg_done change,busy,reject=%b credit=%0d exp 000/0", {change, busy, reject}, credit); else passed++;
  endtask

  task automatic test_deny_reject();
    int n;
    do_reset();
    put_coin(2'b10);
    sel = 2'd1; buy = 1'b1; tick(); buy = 1'b0;
    total++; if ({deny, product} !== 2'b10 || credit !== 5'd2) $display("FAIL deny_low deny,product=%b credit=%0d exp 10/2", {deny, product}, credit); else passed++;
    tick();
    total++; if (deny !== 1'b0 || credit !== 5'd2) $display("FAIL deny_width deny=%b credit=%0d exp 0/2", deny, credit); else passed++;
    repeat (5) put_coin(2'b11);
    put_coin(2'b01);
    put_coin(2'b10);
    total++; if (credit !== 5'd30) $display("FAIL fill30 got=%0d exp=30", credit); else passed++;
    put_coin(2'b10);
    total++; if (reject !== 1'b1 || credit !== 5'd30) $display("FAIL overflow reject=%b credit=%0d exp 1/30", reject, credit); else passed++;
    put_coin(2'b01);
    total++; if (reject !== 1'b0 || credit !== 5'd31) $display("FAIL fill_max reject=%b credit=%0d exp 0/31", reject, credit); else passed++;
    put_coin(2'b01);
    total++; if (reject !== 1'b1 || credit !== 5'd31) $display("FAIL at_max reject=%b credit=%0d exp 1/31", reject, credit); else passed++;
    coin = 2'b11; sel = 2'd1; buy = 1'b1; tick(); buy = 1'b0; coin = 2'b00;
    total++; if ({product, reject} !== 2'b11 || credit !== 5'd28) $display("FAIL buy_wins product,reject=%b credit=%0d exp 11/28", {product, reject}, credit); else passed++;
    tick();
    n = 0;
    for (int k = 0; k < 60 && busy; k++) begin n += int'(change); tick(); end
    total++; if (n !== 28 || busy !== 1'b0 || credit !== 5'd0) $display("FAIL big_change pulses=%0d busy=%b credit=%0d exp 28/0/0", n, busy, credit); else passed++;
  endtask

  task automatic test_sold_out();
    int ok;
    do_reset();
    ok = 0;
    for (int k = 0; k < 8; k++) begin
      put_coin(2'b01); put_coin(2'b10);
      sel = 2'd3; buy = 1'b1; tick(); buy = 1'b0;
      ok += int'(product && product_id == 2'd3);
      tick();
    end
    total++; if (ok !== 8) $display("FAIL stock_vends got=%0d exp=8", ok); else passed++;
    total++; if (sold_out !== 4'b1000) $display("FAIL sold_out_set got=%b exp=1000", sold_out); else passed++;
    put_coin(2'b01); put_coin(2'b10);
    sel = 2'd3; buy = 1'b1; tick(); buy = 1'b0;
    total++; if ({deny, product} !== 2'b10 || credit !== 5'd3 || sold_out !== 4'b1000) $display("FAIL sold_out_deny deny,product=%b credit=%0d sold_out=%b exp 10/3/1000", {deny, product}, credit, sold_out); else passed++;
  endtask

  task automatic test_reset_mid();
    put_coin(2'b11);
    sel = 2'd0; buy = 1'b1; tick(); buy = 1'b0;
    tick();
    total++; if (change !== 1'b1 || credit !== 5'd4) $display("FAIL mid_pre change=%b credit=%0d exp 1/4", change, credit); else passed++;
    reset = 1'b1; tick(); reset = 1'b0;
    total++; if ({change, busy, product} !== 3'b000 || credit !== 5'd0 || sold_out !== 4'b0000) $display("FAIL mid_reset cbp=%b credit=%0d sold_out=%b exp 000/0/0000", {change, busy, product}, credit, sold_out); else passed++;
    tick();
    total++; if (change !== 1'b0 || credit !== 5'd0) $display("FAIL mid_after change=%b credit=%0d exp 0/0", change, credit); else passed++;
  endtask

`ifdef VM_REFUND_EN
  task automatic test_refund();
    int n;
    do_reset();
    cancel = 1'b1; tick(); cancel = 1'b0;
    total++; if ({change, busy} !== 2'b00) $display("FAIL cancel_idle change,busy=%b exp 00", {change, busy}); else passed++;
    put_coin(2'b01); put_coin(2'b10); put_coin(2'b01);
    cancel = 1'b1; tick(); cancel = 1'b0;
    total++; if ({change, busy} !== 2'b11 || credit !== 5'd3) $display("FAIL cancel_first change,busy=%b credit=%0d exp 11/3", {change, busy}, credit); else passed++;
    n = 0;
    for (int k = 0; k < 20 && busy; k++) begin n += int'(change); tick(); end
    total++; if (n !== 4 || busy !== 1'b0 || credit !== 5'd0) $display("FAIL cancel_pulses pulses=%0d busy=%b credit=%0d exp 4/0/0", n, busy, credit); else passed++;
    put_coin(2'b01); put_coin(2'b10); put_coin(2'b01);
    cancel = 1'b1; tick(); cancel = 1'b0;
    tick();
    total++; if (change !== 1'b1 || credit !== 5'd2) $display("FAIL cancel_second change=%b credit=%0d exp 1/2", change, credit); else passed++;
    reset = 1'b1; tick(); reset = 1'b0;
    total++; if ({change, busy} !== 2'b00 || credit !== 5'd0) $display("FAIL cancel_reset change,busy=%b credit=%0d exp 00/0", {change, busy}, credit); else passed++;
    put_coin(2'b01);
    total++; if (credit !== 5'd1) $display("FAIL cancel_reset_idle got=%0d exp=1", credit); else passed++;
  endtask
`endif

  task automatic test_random();
    logic [1:0] c, s;
    logic       b, ok, e_prod, e_rej, e_deny;
    logic [1:0] e_pid;
    logic [3:0] e_so;
    int n;
    do_reset();
    for (int step = 0; step < 400; step++) begin
      int r;
      r = int'($urandom_range(0, 9));
      c = (r < 6) ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3));
      b = r >= 6;
      s = 2'($urandom_range(0, 3));
      ok = b && m_credit >= 3 && m_stock[s] > 0;
      e_prod = ok; e_pid = ok ? s : 2'd0; e_deny = b && !ok;
      if (ok) begin
        e_rej = c != 2'b00;
        m_credit -= 3;
        m_stock[s]--;
      end else if (c != 2'b00 && m_credit + coin_val[c] <= 31) begin
        e_rej = 1'b0;
        m_credit += coin_val[c];
      end else e_rej = c != 2'b00;
      foreach (m_stock[i]) e_so[i] = m_stock[i] == 0;
      coin = c; buy = b; sel = s; tick(); coin = 2'b00; buy = 1'b0;
      total++; if ({product, product_id, reject, deny, credit, sold_out} !== {e_prod, e_pid, e_rej, e_deny, 5'(m_credit), e_so}) $display("FAIL rnd_step%0d got p=%b id=%0d rej=%b deny=%b credit=%0d so=%b exp p=%b id=%0d rej=%b deny=%b credit=%0d so=%b", step, product, product_id, reject, deny, credit, sold_out, e_prod, e_pid, e_rej, e_deny, m_credit, e_so); else passed++;
      if (ok) begin
        tick();
        n = 0;
        for (int k = 0; k < 40 && busy; k++) begin n += int'(change); tick(); end
        total++; if (n !== m_credit || busy !== 1'b0 || credit !== 5'd0) $display("FAIL rnd_change%0d pulses=%0d busy=%b credit=%0d exp %0d/0/0", step, n, busy, credit, m_credit); else passed++;
        m_credit = 0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_change();
    test_deny_reject();
    test_sold_out();
    test_reset_mid();
`ifdef VM_REFUND_EN
    test_refund();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete, passed=%0d total=%0d", passed, total);
    $fatal(1);
  end
endmodule
